// File: rtl/mdio_slave.sv
// MDIO management-frame responder (PHY side): decodes clause-22 style frames
// sampled on MDC rising edges, serves reads serially and commits writes to a local register file.
module mdio_slave #(
    parameter logic [4:0] PHY_ADDR  = 5'd1,
    parameter int         REG_COUNT = 32
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        MDC,
    input  logic        MDIO_IN,
    output logic        MDIO_OUT,
    output logic        MDIO_OE,
    output logic        REG_WR,
    output logic [4:0]  REG_ADDR,
    output logic [15:0] REG_WDATA
);
    localparam int IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic [3:0] {
        S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA, S_WDATA, S_RDATA, S_SKIP
    } state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        mdc_q_reg;
    logic        rise, fall;
    logic [15:0] shift_reg;
    logic [15:0] shift_in;
    logic        is_read_reg;
    logic [4:0]  regad_reg;
    logic        wr_pending_reg;
    logic [15:0] rd_shift_reg;
    logic [15:0] rd_word_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [15:0] mem [0:DEPTH-1];
    logic        addr_ok;
    logic        rd_ok;

    assign rise     = MDC & ~mdc_q_reg;
    assign fall     = ~MDC & mdc_q_reg;
    assign shift_in = {shift_reg[14:0], MDIO_IN};
    assign addr_ok  = ({1'b0, regad_reg} < 6'(REG_COUNT));
    // The RAM has no reset; a per-entry valid bit makes never-written entries read as zero.
    assign rd_ok    = addr_ok & valid_reg[regad_reg[IDX_W-1:0]];

    // cnt_reg holds the frame index of the next bit to be sampled.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        if (rise) begin
            cnt_next = cnt_reg - 5'd1;
            unique case (state_reg)
                S_IDLE: begin
                    cnt_next = 5'd30;
                    if (!MDIO_IN) state_next = S_ST1;
                end
                S_ST1:   state_next = MDIO_IN ? S_OP : S_IDLE;
                S_OP: begin
                    if (cnt_reg == 5'd28)
                        state_next = (shift_in[1:0] == 2'b01 || shift_in[1:0] == 2'b10) ? S_PHYAD : S_SKIP;
                end
                S_PHYAD: begin
                    if (cnt_reg == 5'd23)
                        state_next = (shift_in[4:0] == PHY_ADDR) ? S_REGAD : S_SKIP;
                end
                S_REGAD: if (cnt_reg == 5'd18) state_next = S_TA;
                S_TA:    if (cnt_reg == 5'd16) state_next = is_read_reg ? S_RDATA : S_WDATA;
                S_WDATA: if (cnt_reg == 5'd0) state_next = S_IDLE;
                S_RDATA: state_next = S_RDATA;
                S_SKIP:  if (cnt_reg == 5'd0) state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end else if (fall && state_reg == S_RDATA && cnt_reg == 5'd31) begin
            // counter wrapped past bit 0: this is the fall that ends the read
            state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg      <= S_IDLE;
            cnt_reg        <= 5'd31;
            mdc_q_reg      <= 1'b0;
            shift_reg      <= 16'h0000;
            is_read_reg    <= 1'b0;
            regad_reg      <= 5'd0;
            wr_pending_reg <= 1'b0;
            rd_shift_reg   <= 16'h0000;
            valid_reg      <= '0;
            MDIO_OUT       <= 1'b0;
            MDIO_OE        <= 1'b0;
            REG_WR         <= 1'b0;
            REG_ADDR       <= 5'd0;
            REG_WDATA      <= 16'h0000;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mdc_q_reg <= MDC;
            REG_WR    <= 1'b0;
            if (rise) begin
                shift_reg <= shift_in;
                if (state_reg == S_OP && cnt_reg == 5'd28)
                    is_read_reg <= (shift_in[1:0] == 2'b10);
                if (state_reg == S_REGAD && cnt_reg == 5'd18)
                    regad_reg <= shift_in[4:0];
                if (state_reg == S_TA && cnt_reg == 5'd16)
                    rd_shift_reg <= rd_ok ? rd_word_reg : 16'h0000;
                if (state_reg == S_WDATA && cnt_reg == 5'd0)
                    wr_pending_reg <= 1'b1;
            end
            // Commit one clk after the last data rise, so no output moves on a rise edge.
            if (wr_pending_reg) begin
                wr_pending_reg <= 1'b0;
                REG_WR         <= 1'b1;
                REG_ADDR       <= regad_reg;
                REG_WDATA      <= shift_reg;
                if (addr_ok) valid_reg[regad_reg[IDX_W-1:0]] <= 1'b1;
            end
            if (fall) begin
                if (state_reg == S_TA && is_read_reg && cnt_reg == 5'd16) begin
                    MDIO_OE  <= 1'b1;
                    MDIO_OUT <= 1'b0;
                end else if (state_reg == S_RDATA) begin
                    if (cnt_reg == 5'd31) begin
                        MDIO_OE  <= 1'b0;
                        MDIO_OUT <= 1'b0;
                    end else begin
                        MDIO_OUT     <= rd_shift_reg[15];
                        rd_shift_reg <= {rd_shift_reg[14:0], 1'b0};
                    end
                end
            end
        end
    end

    // Register file: array with registered read of the latched register address.
    always_ff @(posedge clk) begin
        if (wr_pending_reg && !RESET && addr_ok)
            mem[regad_reg[IDX_W-1:0]] <= shift_reg;
        rd_word_reg <= mem[regad_reg[IDX_W-1:0]];
    end
endmodule

// File: tb/tb_mdio_slave.sv
// Self-checking bench for mdio_slave: directed and random MDIO frames
// compared against a register-array model of the responder.
module tb_mdio_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic        mdio_out, mdio_oe, reg_wr;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          wr_count = 0;
    logic [4:0]  last_addr;
    logic [15:0] last_data;
    logic [15:0] model [0:7];

    mdio_slave #(.PHY_ADDR(5'd1), .REG_COUNT(8)) dut (
        .clk(clk), .RESET(rst), .MDC(mdc), .MDIO_IN(mdio_in),
        .MDIO_OUT(mdio_out), .MDIO_OE(mdio_oe), .REG_WR(reg_wr),
        .REG_ADDR(reg_addr), .REG_WDATA(reg_wdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            wr_count++;
            last_addr = reg_addr;
            last_data = reg_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One MDC period as the master drives it: data set while MDC low, sampled at the rise.
    task automatic drive_bit(input logic b, output logic oe_s, output logic out_s);
        mdio_in = b;
        repeat (4) @(negedge clk);
        if ($urandom_range(0, 63) == 0) repeat (100) @(negedge clk);
        oe_s  = mdio_oe;
        out_s = mdio_out;
        mdc   = 1'b1;
        repeat (4) @(negedge clk);
        mdc   = 1'b0;
    endtask

    task automatic run_frame(input logic bad_start, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] ra, input logic [15:0] data, input int rst_bit,
                             output logic [31:0] oe_vec, output logic [31:0] out_vec,
                             output logic tail_oe, output logic tail_out);
        logic [31:0] frame;
        logic b, o, d;
        frame = {2'b01, op, phy, ra, 2'b10, data};
        if (bad_start) begin
            drive_bit(1'b0, o, d);
            drive_bit(1'b0, o, d);
        end
        for (int k = 0; k < 4; k++) drive_bit(1'b1, o, d);
        for (int i = 31; i >= 0; i--) begin
            b = (op == 2'b10 && i <= 17) ? 1'b1 : frame[i];
            drive_bit(b, o, d);
            oe_vec[i]  = o;
            out_vec[i] = d;
            if (i == rst_bit) begin
                rst = 1'b1;
                @(negedge clk);
                check("reset_mid_frame.oe", {31'b0, mdio_oe}, 32'h0);
                rst = 1'b0;
            end
        end
        drive_bit(1'b1, tail_oe, tail_out);
    endtask

    task automatic do_frame(input string tag, input logic bad_start, input logic [1:0] op,
                            input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] data,
                            input int rst_bit);
        logic [31:0] oe_vec, out_vec, keep, exp_oe, exp_out;
        logic        tail_oe, tail_out, mine, is_wr, is_rd;
        logic [15:0] rd;
        mine  = (phy == 5'd1);
        is_wr = mine && op == 2'b01 && rst_bit < 0;
        is_rd = mine && op == 2'b10;
        rd    = (ra < 5'd8) ? model[ra[2:0]] : 16'h0000;
        wr_count = 0;
        run_frame(bad_start, op, phy, ra, data, rst_bit, oe_vec, out_vec, tail_oe, tail_out);
        keep    = (rst_bit < 0) ? 32'hFFFF_FFFF : ~((32'd1 << rst_bit) - 32'd1);
        exp_oe  = is_rd ? (32'h0001_FFFF & keep) : 32'h0;
        exp_out = is_rd ? ({16'h0, rd} & keep) : 32'h0;
        check({tag, ".oe"}, oe_vec, exp_oe);
        check({tag, ".out"}, out_vec, exp_out);
        check({tag, ".tail_oe"}, {31'b0, tail_oe}, 32'h0);
        check({tag, ".tail_out"}, {31'b0, tail_out}, 32'h0);
        check({tag, ".wr_pulses"}, wr_count, is_wr ? 32'd1 : 32'd0);
        if (is_wr) begin
            check({tag, ".reg_addr"}, {27'b0, last_addr}, {27'b0, ra});
            check({tag, ".reg_wdata"}, {16'h0, last_data}, {16'h0, data});
            if (ra < 5'd8) model[ra[2:0]] = data;
        end
        if (rst_bit >= 0) for (int k = 0; k < 8; k++) model[k] = 16'h0000;
        $display("frame %s op=%b phy=%0d reg=%0d data=%h oe=%h out=%h wr=%0d",
                 tag, op, phy, ra, data, oe_vec, out_vec, wr_count);
    endtask

    initial begin
        for (int k = 0; k < 8; k++) model[k] = 16'h0000;
        repeat (5) @(negedge clk);
        check("reset.mdio_oe", {31'b0, mdio_oe}, 32'h0);
        check("reset.mdio_out", {31'b0, mdio_out}, 32'h0);
        check("reset.reg_wr", {31'b0, reg_wr}, 32'h0);
        check("reset.reg_addr", {27'b0, reg_addr}, 32'h0);
        check("reset.reg_wdata", {16'h0, reg_wdata}, 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        do_frame("write_r3", 1'b0, 2'b01, 5'd1, 5'd3, 16'hA5C3, -1);
        do_frame("read_r3", 1'b0, 2'b10, 5'd1, 5'd3, 16'h0000, -1);
        do_frame("read_phy2", 1'b0, 2'b10, 5'd2, 5'd3, 16'h0000, -1);
        do_frame("op11", 1'b0, 2'b11, 5'd1, 5'd3, 16'h1234, -1);
        do_frame("read_r3_again", 1'b0, 2'b10, 5'd1, 5'd3, 16'h0000, -1);
        do_frame("badstart_write_r0", 1'b1, 2'b01, 5'd1, 5'd0, 16'h0001, -1);
        do_frame("read_r0", 1'b0, 2'b10, 5'd1, 5'd0, 16'h0000, -1);
        do_frame("write_r9", 1'b0, 2'b01, 5'd1, 5'd9, 16'hBEEF, -1);
        do_frame("read_r9", 1'b0, 2'b10, 5'd1, 5'd9, 16'h0000, -1);

        for (int n = 0; n < 30; n++) begin
            logic [1:0]  op;
            logic [4:0]  phy, ra;
            logic [15:0] data;
            op   = 2'($urandom_range(0, 3));
            phy  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'd1;
            ra   = 5'($urandom_range(0, 15));
            data = 16'($urandom);
            do_frame("random", 1'b0, op, phy, ra, data, -1);
        end

        do_frame("rewrite_r3", 1'b0, 2'b01, 5'd1, 5'd3, 16'hA5C3, -1);
        do_frame("read_r3_reset", 1'b0, 2'b10, 5'd1, 5'd3, 16'h0000, 8);
        do_frame("read_r3_after_reset", 1'b0, 2'b10, 5'd1, 5'd3, 16'h0000, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
